// File: rtl/spectrum_frame_scheduler.sv
// Double-buffered FFT bin store: bins fill a shadow bank and become visible on vblank rise.
// Optional PEAK_DECAY_EN: each new bin is max(new, display - DECAY_STEP) so bars fall slowly.
module spectrum_frame_scheduler #(
  parameter int                 NUM_BINS   = 16,
  parameter int                 DATA_W     = 16,
  parameter logic [DATA_W-1:0]  DECAY_STEP = 16'd8,
  parameter int                 MISS_W     = 8,
  localparam int                IDX_W      = $clog2(NUM_BINS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              vblank,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_swap,
  output logic [MISS_W-1:0] missed_frames,
  output logic [1:0]        state
);

  // in_valid/in_ready: a beat transfers on any cycle where both are high;
  // in_ready is low from the accepted in_last until the bank swap completes.

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    SWAP    = 2'd2
  } state_e;

  state_e              state_q;
  logic                ptr_q;
  logic                vblank_d_q;
  logic                in_ready_q;
  logic                frame_swap_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [MISS_W-1:0]   missed_q;
  logic [DATA_W-1:0]   bank_q [2][NUM_BINS];

  logic                accept;
  logic                vblank_rise;
  logic [DATA_W-1:0]   clamped;
  logic [DATA_W-1:0]   wr_data;

  assign accept      = in_valid & in_ready_q;
  assign vblank_rise = vblank & ~vblank_d_q;
  assign clamped     = in_data[DATA_W-1] ? '0 : in_data;

`ifdef PEAK_DECAY_EN
  logic [DATA_W-1:0] disp;
  logic [DATA_W-1:0] decayed;
  assign disp    = bank_q[ptr_q][in_index];
  assign decayed = (disp > DECAY_STEP) ? (disp - DECAY_STEP) : '0;
  assign wr_data = (clamped > decayed) ? clamped : decayed;
`else
  logic unused_decay_step;
  assign unused_decay_step = ^DECAY_STEP;
  assign wr_data = clamped;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      ptr_q        <= 1'b0;
      vblank_d_q   <= 1'b1;
      in_ready_q   <= 1'b1;
      frame_swap_q <= 1'b0;
      rd_data_q    <= '0;
      missed_q     <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_BINS; i++)
          bank_q[b][i] <= '0;
    end else begin
      vblank_d_q   <= vblank;
      frame_swap_q <= 1'b0;
      // Read uses the pointer in effect this cycle, so a SWAP-cycle read returns old data.
      rd_data_q    <= bank_q[ptr_q][rd_index];
      if (accept)
        bank_q[~ptr_q][in_index] <= wr_data;
      case (state_q)
        COLLECT: begin
          if (accept && in_last) begin
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end
          // A rise while collecting is a miss even if in_last lands on the same cycle.
          if (vblank_rise && (missed_q != {MISS_W{1'b1}}))
            missed_q <= missed_q + MISS_W'(1);
        end
        FULL: begin
          if (vblank_rise) begin
            state_q      <= SWAP;
            frame_swap_q <= 1'b1;
          end
        end
        SWAP: begin
          ptr_q      <= ~ptr_q;
          for (int i = 0; i < NUM_BINS; i++)
            bank_q[ptr_q][i] <= '0;
          state_q    <= COLLECT;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= COLLECT;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign frame_swap    = frame_swap_q;
  assign rd_data       = rd_data_q;
  assign missed_frames = missed_q;
  assign state         = state_q;

endmodule

// File: tb/tb_spectrum_frame_scheduler.sv
// Directed bench for spectrum_frame_scheduler; expectations honour PEAK_DECAY_EN when defined.
module tb_spectrum_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_index;
  logic [15:0] in_data;
  logic        in_last;
  logic        vblank;
  logic [3:0]  rd_index;
  logic [15:0] rd_data;
  logic        frame_swap;
  logic [7:0]  missed_frames;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

`ifdef PEAK_DECAY_EN
  localparam logic [15:0] EXP_T2_IDX1 = 16'd93;
  localparam logic [15:0] EXP_T2_IDX3 = 16'd95;
  localparam logic [15:0] EXP_T4_IDX0 = 16'd84;
  localparam logic [15:0] EXP_T6_DEC  = 16'd42;
`else
  localparam logic [15:0] EXP_T2_IDX1 = 16'd8;
  localparam logic [15:0] EXP_T2_IDX3 = 16'd0;
  localparam logic [15:0] EXP_T4_IDX0 = 16'd33;
  localparam logic [15:0] EXP_T6_DEC  = 16'd10;
`endif

  spectrum_frame_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_index      (in_index),
    .in_data       (in_data),
    .in_last       (in_last),
    .vblank        (vblank),
    .rd_index      (rd_index),
    .rd_data       (rd_data),
    .frame_swap    (frame_swap),
    .missed_frames (missed_frames),
    .state         (state)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input int idx, input logic [15:0] data, input logic last);
    in_valid = 1'b1;
    in_index = 4'(idx);
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_bin(input string tag, input int idx, input logic [15:0] exp);
    rd_index = 4'(idx);
    tick();
    check(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic vblank_pulse(input logic exp_swap, input string tag);
    vblank = 1'b1;
    tick();
    check(tag, {31'd0, frame_swap}, {31'd0, exp_swap});
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_index = '0; in_data = '0; in_last = 1'b0;
    vblank = 1'b0; rd_index = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_frame_swap", {31'd0, frame_swap}, 32'd0);
    check("rst_missed", {24'd0, missed_frames}, 32'd0);
    tick();

    // Full set 100..115, swap, SWAP-cycle read returns old bank
    for (int i = 0; i < 16; i++) send_beat(i, 16'(100 + i), i == 15);
    check("t1_full_state", {30'd0, state}, 32'd1);
    check("t1_full_ready", {31'd0, in_ready}, 32'd0);
    vblank = 1'b1;
    tick();
    check("t1_swap_pulse", {31'd0, frame_swap}, 32'd1);
    check("t1_swap_state", {30'd0, state}, 32'd2);
    check("t1_swap_ready", {31'd0, in_ready}, 32'd0);
    rd_index = 4'd5;
    tick();
    check("t1_swapcycle_read_old", {16'd0, rd_data}, 32'd0);
    check("t1_post_state", {30'd0, state}, 32'd0);
    check("t1_pulse_one_cycle", {31'd0, frame_swap}, 32'd0);
    check("t1_post_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("t1_rd5", {16'd0, rd_data}, 32'd105);
    vblank = 1'b0;
    read_bin("t1_rd15", 15, 16'd115);
    read_bin("t1_rd0", 0, 16'd100);
    check("t1_missed", {24'd0, missed_frames}, 32'd0);

    // Negative clamp
    send_beat(0, 16'd7, 1'b0);
    send_beat(1, 16'd8, 1'b0);
    send_beat(2, 16'd9, 1'b0);
    send_beat(3, 16'hFF38, 1'b1);
    vblank_pulse(1'b1, "t2_swap_pulse");
    read_bin("t2_rd3_clamped", 3, EXP_T2_IDX3);
    read_bin("t2_rd1", 1, EXP_T2_IDX1);
    read_bin("t2_rd5_unwritten", 5, 16'd0);

    // Missed frames, one held vblank counts once
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t3_held_no_swap", {31'd0, frame_swap}, 32'd0);
    vblank = 1'b0;
    tick();
    check("t3_held_once", {24'd0, missed_frames}, 32'd1);
    vblank_pulse(1'b0, "t3_no_swap_a");
    vblank_pulse(1'b0, "t3_no_swap_b");
    check("t3_missed3", {24'd0, missed_frames}, 32'd3);
    check("t3_state", {30'd0, state}, 32'd0);

    // Input blocked while FULL; old display bank cleared on earlier swap
    send_beat(0, 16'd33, 1'b1);
    in_valid = 1'b1; in_index = 4'd0; in_data = 16'd77; in_last = 1'b1;
    tick();
    check("t4_full_ready", {31'd0, in_ready}, 32'd0);
    check("t4_full_state", {30'd0, state}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    vblank_pulse(1'b1, "t4_swap_pulse");
    check("t4_ready_again", {31'd0, in_ready}, 32'd1);
    read_bin("t4_rd0_unchanged", 0, EXP_T4_IDX0);
    read_bin("t4_rd5_cleared", 5, 16'd0);

    // in_last on the same cycle as vblank rise
    send_beat(0, 16'd200, 1'b0);
    vblank = 1'b1;
    send_beat(1, 16'd201, 1'b1);
    check("t5_state_full", {30'd0, state}, 32'd1);
    check("t5_missed", {24'd0, missed_frames}, 32'd4);
    check("t5_no_swap", {31'd0, frame_swap}, 32'd0);
    tick();
    check("t5_still_full", {30'd0, state}, 32'd1);
    vblank = 1'b0;
    tick();
    vblank_pulse(1'b1, "t5_next_rise_swaps");
    read_bin("t5_rd1", 1, 16'd201);

    // Peak decay sequence
    send_beat(2, 16'd50, 1'b1);
    vblank_pulse(1'b1, "t6_swap_a");
    read_bin("t6_rd2_50", 2, 16'd50);
    send_beat(2, 16'd10, 1'b1);
    vblank_pulse(1'b1, "t6_swap_b");
    read_bin("t6_rd2_decay", 2, EXP_T6_DEC);
    send_beat(2, 16'd60, 1'b1);
    vblank_pulse(1'b1, "t6_swap_c");
    read_bin("t6_rd2_rise", 2, 16'd60);
    check("t6_missed", {24'd0, missed_frames}, 32'd4);

    // Saturation of missed counter
    for (int i = 0; i < 260; i++) begin
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
    end
    check("t3_saturated", {24'd0, missed_frames}, 32'd255);

    // Reset mid-set discards partial data
    send_beat(2, 16'd99, 1'b0);
    send_beat(3, 16'd98, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_state", {30'd0, state}, 32'd0);
    check("t7_missed", {24'd0, missed_frames}, 32'd0);
    check("t7_ready", {31'd0, in_ready}, 32'd1);
    send_beat(5, 16'd1, 1'b1);
    vblank_pulse(1'b1, "t7_swap");
    read_bin("t7_rd2_discarded", 2, 16'd0);
    read_bin("t7_rd5", 5, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
